// File: rtl/pcie_axi_to_sram_rd_if.sv
// AXI4 read channel plus synchronous-read SRAM port for the message-SRAM read bridge.
// slave = bridge view, master = AXI master / SRAM side.
interface pcie_axi_to_sram_rd_if #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH      = 12
);
  logic                      axi_arvalid;
  logic [AXI_ADDR_WIDTH-1:0] axi_araddr;
  logic [LEN_WIDTH-1:0]      axi_arlen;
  logic [2:0]                axi_arsize;
  logic [1:0]                axi_arburst;
  logic                      axi_arready;
  logic                      axi_rvalid;
  logic [DATA_WIDTH-1:0]     axi_rdata;
  logic [1:0]                axi_rresp;
  logic                      axi_rlast;
  logic                      axi_rready;
  logic                      sram_ren;
  logic [ADDR_WIDTH-1:0]     sram_raddr;
  logic [DATA_WIDTH-1:0]     sram_rdata;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready, sram_rdata,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, sram_ren, sram_raddr
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready, sram_rdata,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, sram_ren, sram_raddr
  );
endinterface

// File: rtl/pcie_axi_to_sram_rd.sv
// AXI4 read slave fetching one burst at a time from a synchronous-read SRAM.
// Optional PCIE_AXI_TO_SRAM_PIPELINE_EN: 2-entry R FIFO, one beat per cycle; default is a 3-cycle/beat FSM.
module pcie_axi_to_sram_rd #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH      = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  pcie_axi_to_sram_rd_if.slave   bus
);
  localparam int BO = $clog2(DATA_WIDTH / 8);

  logic [AXI_ADDR_WIDTH-1:0] w_araddr;
  logic [ADDR_WIDTH-1:0]     w_ar_word;
  logic [1:0]                w_ar_resp;
  logic                      w_ar_fixed;
  logic                      w_unused_addr;

  logic                      w_arready;
  logic                      w_rvalid;
  logic                      w_rlast;
  logic                      w_ren;
  logic [DATA_WIDTH-1:0]     w_rdata;
  logic [ADDR_WIDTH-1:0]     w_raddr;
  logic [1:0]                r_resp;

  assign w_araddr      = bus.axi_araddr;
  assign w_ar_word     = w_araddr[BO +: ADDR_WIDTH];
  assign w_ar_resp     = (bus.axi_arsize == 3'(BO)) ? 2'b00 : 2'b10;
  assign w_ar_fixed    = (bus.axi_arburst == 2'b00);
  // Bits outside the word-address field are deliberately ignored.
  assign w_unused_addr = ^w_araddr;

  assign bus.axi_arready = w_arready;
  assign bus.axi_rvalid  = w_rvalid;
  assign bus.axi_rdata   = w_rdata;
  assign bus.axi_rresp   = r_resp;
  assign bus.axi_rlast   = w_rlast;
  assign bus.sram_ren    = w_ren;
  assign bus.sram_raddr  = w_raddr;

`ifdef PCIE_AXI_TO_SRAM_PIPELINE_EN
  localparam logic [LEN_WIDTH:0] ONE_LEFT = 1;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [LEN_WIDTH:0]    r_left;
  logic                  r_fixed;
  logic                  r_infl;
  logic                  r_infl_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_cnt;

  logic w_issue;
  logic w_ar_hs;
  logic w_push;
  logic w_pop;
  logic w_fifo_empty;

  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_issue      = (r_left != '0) && ((r_fifo_cnt + 2'(r_infl)) < 2'd2);
  assign w_arready    = (r_left == '0) && !r_infl && w_fifo_empty;
  assign w_ar_hs      = bus.axi_arvalid && w_arready;
  assign w_rvalid     = !w_fifo_empty || r_infl;
  // With an empty FIFO the SRAM output is forwarded directly; it is queued only if not accepted.
  assign w_pop        = !w_fifo_empty && bus.axi_rready;
  assign w_push       = r_infl && !(w_fifo_empty && bus.axi_rready);
  assign w_rdata      = !w_fifo_empty ? r_fifo_data[r_rd_ptr] : (r_infl ? bus.sram_rdata : '0);
  assign w_rlast      = !w_fifo_empty ? r_fifo_last[r_rd_ptr] : (r_infl && r_infl_last);
  assign w_ren        = w_issue;
  assign w_raddr      = w_issue ? r_addr : r_raddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_raddr     <= '0;
      r_left      <= '0;
      r_fixed     <= 1'b0;
      r_resp      <= 2'b00;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_infl <= w_issue;
      if (w_ar_hs) begin
        r_addr  <= w_ar_word;
        r_left  <= {1'b0, bus.axi_arlen} + ONE_LEFT;
        r_fixed <= w_ar_fixed;
        r_resp  <= w_ar_resp;
      end else if (w_issue) begin
        r_raddr     <= r_addr;
        r_left      <= r_left - ONE_LEFT;
        r_infl_last <= (r_left == ONE_LEFT);
        if (!r_fixed) r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.sram_rdata;
      r_fifo_last[r_wr_ptr] <= r_infl_last;
    end
  end

`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_fixed;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_last_beat;

  assign w_ar_hs     = bus.axi_arvalid && (r_state == S_IDLE);
  assign w_r_hs      = (r_state == S_SEND) && bus.axi_rready;
  assign w_last_beat = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ar_hs) w_state_next = S_RD;
      S_RD:    w_state_next = S_CAP;
      S_CAP:   w_state_next = S_SEND;
      S_SEND:  if (bus.axi_rready) w_state_next = w_last_beat ? S_IDLE : S_RD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_rlast   = 1'b0;
    w_ren     = 1'b0;
    case (r_state)
      S_IDLE:  w_arready = 1'b1;
      S_RD:    w_ren     = 1'b1;
      S_SEND: begin
        w_rvalid = 1'b1;
        w_rlast  = w_last_beat;
      end
      default: ;
    endcase
  end

  // r_addr only moves when entering RD, so it doubles as the held SRAM address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_resp  <= 2'b00;
      r_rdata <= '0;
    end else begin
      if (w_ar_hs) begin
        r_addr  <= w_ar_word;
        r_cnt   <= bus.axi_arlen;
        r_fixed <= w_ar_fixed;
        r_resp  <= w_ar_resp;
      end
      if (r_state == S_CAP) r_rdata <= bus.sram_rdata;
      if (w_r_hs && !w_last_beat) begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
        if (!r_fixed) r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign w_rdata = r_rdata;
  assign w_raddr = r_addr;
`endif

endmodule

// File: tb/tb_pcie_axi_to_sram_rd.sv
// Directed bench for pcie_axi_to_sram_rd: SRAM model plus scoreboard queues of expected beats and reads.
module tb_pcie_axi_to_sram_rd;
  localparam int DW  = 256;
  localparam int AW  = 10;
  localparam int AAW = 64;
  localparam int LW  = 12;
  localparam int BO  = 5;
`ifdef PCIE_AXI_TO_SRAM_PIPELINE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_axi_to_sram_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AXI_ADDR_WIDTH(AAW), .LEN_WIDTH(LW)) bus ();

  pcie_axi_to_sram_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AXI_ADDR_WIDTH(AAW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [1024];
  always @(posedge clk) if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_raddr];

  logic [DW-1:0] exp_data [$];
  logic [1:0]    exp_resp [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_ra   [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_ar(input logic [AAW-1:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst);
    logic [AW-1:0] a;
    int w;
    a = addr[BO +: AW];
    for (int i = 0; i <= len; i++) begin
      exp_data.push_back(mem[a]);
      exp_resp.push_back((size == 3'(BO)) ? 2'b00 : 2'b10);
      exp_last.push_back(i == len);
      exp_ra.push_back(a);
      if (burst != 2'b00) a = a + AW'(1);
    end
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b1;
    bus.axi_araddr  = addr;
    bus.axi_arlen   = LW'(len);
    bus.axi_arsize  = size;
    bus.axi_arburst = burst;
    w = 0;
    @(negedge clk);
    while (!bus.axi_arready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.axi_arready) check("ar_timeout", bus.axi_arready, 1);
    @(posedge clk); #1;
    bus.axi_arvalid = 1'b0;
  endtask

  // Called #1 after the AR handshake edge; cycle 1 is the first cycle after that edge.
  task automatic collect(input int nbeats, input int stall_beat, input bit check_lat);
    int got = 0;
    int cyc = 0;
    int stall_left = 5;
    bit seen = 1'b0;
    logic [DW-1:0] h_data;
    logic [1:0]    h_resp;
    logic          h_last;
    while (got < nbeats && cyc < 400) begin
      bus.axi_rready = !(got == stall_beat && stall_left > 0);
      @(negedge clk);
      cyc++;
      check("arready_busy", bus.axi_arready, 0);
      if (bus.sram_ren) begin
        if (exp_ra.size() == 0) check("extra_sram_read", 1, 0);
        else check("sram_raddr", bus.sram_raddr, exp_ra.pop_front());
      end
      if (bus.axi_rvalid) begin
        if (!seen) begin
          seen = 1'b1;
          if (check_lat) check("first_rvalid_cycle", cyc, LAT);
        end
        if (!bus.axi_rready) begin
          if (stall_left == 5) begin
            h_data = bus.axi_rdata;
            h_resp = bus.axi_rresp;
            h_last = bus.axi_rlast;
          end else begin
            check("stall_rdata", bus.axi_rdata, h_data);
            check("stall_rresp", bus.axi_rresp, h_resp);
            check("stall_rlast", bus.axi_rlast, h_last);
          end
          stall_left--;
        end else if (exp_data.size() == 0) begin
          check("unexpected_beat", 1, 0);
          got++;
        end else begin
          check("rdata", bus.axi_rdata, exp_data.pop_front());
          check("rresp", bus.axi_rresp, exp_resp.pop_front());
          check("rlast", bus.axi_rlast, exp_last.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
    end
    if (got < nbeats) check("beat_timeout", got, nbeats);
    @(negedge clk);
    check("arready_after", bus.axi_arready, 1);
    check("rvalid_after", bus.axi_rvalid, 0);
    check("sram_ren_after", bus.sram_ren, 0);
    check("queue_empty", exp_data.size(), 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 1024; i++) mem[i] = {8{32'(i) ^ 32'hC0DE_0000}};
    mem[0] = 256'hA0; mem[1] = 256'hA1; mem[2] = 256'hA2; mem[3] = 256'hA3;
    bus.axi_arvalid = 1'b0;
    bus.axi_araddr  = '0;
    bus.axi_arlen   = '0;
    bus.axi_arsize  = 3'd5;
    bus.axi_arburst = 2'b01;
    bus.axi_rready  = 1'b1;
    bus.sram_rdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", bus.axi_arready, 1);
    check("rst_rvalid", bus.axi_rvalid, 0);
    check("rst_rlast", bus.axi_rlast, 0);
    check("rst_rresp", bus.axi_rresp, 0);
    check("rst_rdata", bus.axi_rdata, 0);
    check("rst_sram_ren", bus.sram_ren, 0);
    check("rst_sram_raddr", bus.sram_raddr, 0);
    rst = 1'b0;

    send_ar(64'h0, 3, 3'd5, 2'b01);       collect(4, -1, 1'b1);
    send_ar(64'h7FE0, 1, 3'd5, 2'b01);    collect(2, -1, 1'b1);
    send_ar(64'h40, 2, 3'd5, 2'b00);      collect(3, -1, 1'b1);
    send_ar(64'h60, 0, 3'd4, 2'b01);      collect(1, -1, 1'b1);
    send_ar(64'h80, 3, 3'd5, 2'b01);      collect(4, 1, 1'b0);

    // Reset while a beat is presented and held by rready low.
    send_ar(64'hA0, 3, 3'd5, 2'b01);
    bus.axi_rready = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus.axi_rvalid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("pre_reset_rvalid", bus.axi_rvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_rvalid", bus.axi_rvalid, 0);
    check("midrst_arready", bus.axi_arready, 1);
    check("midrst_rlast", bus.axi_rlast, 0);
    check("midrst_rdata", bus.axi_rdata, 0);
    check("midrst_sram_ren", bus.sram_ren, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data.delete();
    exp_resp.delete();
    exp_last.delete();
    exp_ra.delete();
    bus.axi_rready = 1'b1;

    send_ar(64'hFFFF_0000_0000_0021, 3, 3'd5, 2'b10); collect(4, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pcie_axi_to_sram_rd.md
Name: pcie_axi_to_sram_rd

Overview:
AXI4 read-slave bridge: accepts one read burst on AR and fetches each beat from a synchronous-read SRAM. It returns the beats on the R channel with rlast and rresp. It sits between the AXI read master (the message-readback generator) and the message SRAM that the PCIe message receiver fills. Exactly one burst is outstanding at a time.

Parameters:
DATA_WIDTH, 256, AXI data / SRAM word width in bits (power of 2, min 8).
ADDR_WIDTH, 10, SRAM word-address width (depth = 2**ADDR_WIDTH).
AXI_ADDR_WIDTH, 64, AXI byte-address width.
LEN_WIDTH, 12, arlen width; beats = arlen+1.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
axi_arvalid  in  1  AR valid
axi_araddr  in  AXI_ADDR_WIDTH  AR byte address
axi_arlen  in  LEN_WIDTH  beats minus 1
axi_arsize  in  3  beat size code
axi_arburst  in  2  burst type
axi_arready  out  1  AR ready
axi_rvalid  out  1  R valid
axi_rdata  out  DATA_WIDTH  R data
axi_rresp  out  2  R response
axi_rlast  out  1  last beat of burst
axi_rready  in  1  R ready
sram_ren  out  1  SRAM read enable
sram_raddr  out  ADDR_WIDTH  SRAM word address
sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after sram_ren

Behaviour:
- Reset, async: state IDLE; axi_arready=1; axi_rvalid=0; axi_rlast=0; axi_rresp=0; axi_rdata=0; sram_ren=0; sram_raddr=0; internal counters cleared. Reset mid-burst abandons the burst without completing it.
- Byte offset BO = log2(DATA_WIDTH/8), which is 5 for the default width. Start word = araddr[BO+ADDR_WIDTH-1:BO]. Address bits above that range and below BO are ignored.
- States:
  - IDLE: arready=1. On arvalid&arready, latch word address, beat counter = arlen, burst, and resp. Go to RD.
  - RD: arready=0. Assert sram_ren=1 for one cycle with sram_raddr = current word. Go to CAP.
  - CAP: register sram_rdata into axi_rdata. Go to SEND.
  - SEND: rvalid=1, with rdata/rresp/rlast stable until rready.
    - On rready with counter==0: go to IDLE (rlast=1 on this beat).
    - On rready otherwise: decrement counter, advance address, go to RD.
- Latency: first rvalid is the 3rd cycle after the AR handshake edge. Minimum beat spacing is 3 cycles. rready low stalls indefinitely with outputs held.
- Address advance:
  - arburst 2'b00 (FIXED): address held.
  - 2'b01 (INCR), 2'b10 and 2'b11: address +1, wrapping modulo 2**ADDR_WIDTH (1023 -> 0).
- rresp: 2'b00 OKAY when arsize == BO. Otherwise 2'b10 SLVERR on every beat of the burst; the data is still read and returned.
- arlen = 0 gives a single beat with rlast=1. Max arlen 4095 gives 4096 beats.
- sram_ren is never asserted outside RD. sram_raddr holds its last value otherwise.
- arvalid while busy is ignored (arready=0) until return to IDLE. A new AR is accepted in the cycle after the last R handshake.

Optional Feature:
PCIE_AXI_TO_SRAM_PIPELINE_EN:
- Defined: replace RD/CAP/SEND with a 2-entry R output FIFO.
  - Issue sram_ren whenever beats remain and (in-flight reads + FIFO occupancy) < 2.
  - First rvalid on the 2nd cycle after the AR handshake. With rready held high, one beat per cycle.
  - rlast, rresp and address rules are unchanged.
  - arready returns to 1 only when the FIFO is empty and all beats are issued.
- Undefined: the 3-cycle-per-beat FSM above.

Test Plan:
- Preload SRAM[0..3] = 256'hA0..A3; AR araddr=0x0, arlen=3, arsize=5, INCR, rready=1 -> 4 beats A0..A3, rresp=0, rlast only on beat 4, first rvalid 3 cycles after handshake (2 with PIPELINE_EN).
- AR araddr=0x7FE0 (word 1023), arlen=1, INCR -> beats SRAM[1023], then SRAM[0] (wrap).
- AR araddr=0x40, arlen=2, FIXED -> three beats all equal SRAM[2]; sram_raddr=2 each read.
- AR arsize=4, arlen=0 -> single beat with rresp=2'b10, rlast=1, data=SRAM[word].
- rready toggled 0 for 5 cycles mid-burst -> rvalid/rdata/rlast held constant; no beat lost or duplicated; arready=0 throughout burst.
- Assert rst for 1 cycle during SEND of a 4-beat burst -> rvalid=0 immediately, arready=1; next AR burst completes correctly.
